// File: rtl/bp_update_ctrl_pkg.sv
// Shared types for the branch-predictor update controller: update payload and FSM states.
package bp_update_ctrl_pkg;

  localparam int BP_ENTRIES_DEF = 64;
  localparam int BP_QDEPTH_DEF  = 4;
  localparam int BP_DROP_W_DEF  = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_upd_t;

  typedef enum logic {BPC_CLEAR, BPC_IDLE} bp_ctrl_state_e;

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Bundle between the ID/IF pipeline and the predictor update controller.
interface bp_update_ctrl_if #(
  parameter int IDX_W  = 6,
  parameter int DROP_W = 16
);
  logic              flush_req;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic [31:0]       pc_d;
  logic              cflow_valid;
  logic              cflow_taken;
  logic [31:0]       cflow_target;
  logic              clr_valid;
  logic [IDX_W-1:0]  clr_index;
  logic              pred_enable;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output flush_req, upd_valid, upd_pc, upd_taken, upd_target,
    input  pc_d, cflow_valid, cflow_taken, cflow_target,
    input  clr_valid, clr_index, pred_enable, busy, drop_cnt
  );

  modport slave (
    input  flush_req, upd_valid, upd_pc, upd_taken, upd_target,
    output pc_d, cflow_valid, cflow_taken, cflow_target,
    output clr_valid, clr_index, pred_enable, busy, drop_cnt
  );
endinterface

// File: rtl/bp_update_ctrl_upd_fifo.sv
// Update queue: QDEPTH-entry FIFO of bp_upd_t, combinational head, zero-latency flag update.
// Caller must not push when full unless popping; flush empties it at the next edge.
module bp_upd_fifo
  import bp_update_ctrl_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  logic    flush,
  input  bp_upd_t din,
  output bp_upd_t dout,
  output logic    full,
  output logic    empty
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0] wptr, rptr;
  bp_upd_t     mem [QDEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Payload storage carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[PW-1:0]] <= din;
  end

  assign dout  = mem[rptr[PW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

endmodule

// File: rtl/bp_update_ctrl.sv
// BHT/BTB update sequencer: clear sweep after reset/flush, then one queued update per cycle.
// Update reaches cflow_* one edge after acceptance; overflow while full is dropped and counted.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES_DEF,
  parameter int QDEPTH  = BP_QDEPTH_DEF,
  parameter int DROP_W  = BP_DROP_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  bp_update_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  bp_ctrl_state_e    state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DROP_W-1:0] drop_q;
  logic              cflow_valid_q;
  bp_upd_t           cflow_q;

  bp_upd_t upd_in, q_head, issue_dat;
  logic    q_full, q_empty;
  logic    is_idle, live_upd, fifo_pop, bypass, issue, push, drop;

  assign upd_in   = '{pc: bus.upd_pc, taken: bus.upd_taken, target: bus.upd_target};
  assign is_idle  = (state_q == BPC_IDLE);
  assign live_upd = bus.upd_valid && !bus.flush_req;

  // An update arriving at an idle, empty queue goes straight to the output register.
  assign fifo_pop  = is_idle && !bus.flush_req && !q_empty;
  assign bypass    = is_idle && q_empty && live_upd;
  assign issue     = fifo_pop || bypass;
  assign push      = live_upd && !bypass && (!q_full || fifo_pop);
  assign drop      = live_upd && q_full && !fifo_pop;
  assign issue_dat = q_empty ? upd_in : q_head;

  bp_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (fifo_pop),
    .flush (bus.flush_req),
    .din   (upd_in),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BPC_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (bus.flush_req) begin
      state_d = BPC_CLEAR;
      idx_d   = '0;
    end else if (state_q == BPC_CLEAR) begin
      idx_d = idx_q + IDX_ONE;
      if (idx_q == IDX_LAST) state_d = BPC_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cflow_valid_q <= 1'b0;
      cflow_q       <= '0;
      drop_q        <= '0;
    end else begin
      cflow_valid_q <= issue;
      if (issue) cflow_q <= issue_dat;
      if (drop && (drop_q != '1)) drop_q <= drop_q + DROP_ONE;
    end
  end

  assign bus.pc_d         = cflow_q.pc;
  assign bus.cflow_valid  = cflow_valid_q;
  assign bus.cflow_taken  = cflow_q.taken;
  assign bus.cflow_target = cflow_q.target;
  assign bus.clr_valid    = !is_idle;
  assign bus.clr_index    = idx_q;
  assign bus.pred_enable  = is_idle;
  assign bus.busy         = !is_idle || !q_empty || cflow_valid_q;
  assign bus.drop_cnt     = drop_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scenario and randomized checks of bp_update_ctrl against a queue-based reference model.
module tb_bp_update_ctrl;
  import bp_update_ctrl_pkg::*;

  localparam int ENTRIES = 64;
  localparam int QDEPTH  = 4;
  localparam int DROP_W  = 16;
  localparam int IDX_W   = 6;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_update_ctrl_if #(.IDX_W(IDX_W), .DROP_W(DROP_W)) bus ();

  bp_update_ctrl #(.ENTRIES(ENTRIES), .QDEPTH(QDEPTH), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: sweep position (-1 = idle), pending update list, drop count, last issue.
  int          m_sweep;
  bp_upd_t     m_q[$];
  int          m_drop;
  logic        m_cv;
  bp_upd_t     m_out;

  function automatic void model_reset();
    m_sweep = 0;
    m_q.delete();
    m_drop = 0;
    m_cv = 1'b0;
    m_out = '0;
  endfunction

  function automatic void model_edge(input logic f, input logic v, input bp_upd_t nu);
    if (f) begin
      m_sweep = 0;
      m_q.delete();
      m_cv = 1'b0;
    end else if (m_sweep < 0) begin
      m_cv = 1'b0;
      if (m_q.size() > 0) begin
        m_out = m_q.pop_front();
        m_cv = 1'b1;
        if (v) m_q.push_back(nu);
      end else if (v) begin
        m_out = nu;
        m_cv = 1'b1;
      end
    end else begin
      m_cv = 1'b0;
      if (v) begin
        if (m_q.size() < QDEPTH) m_q.push_back(nu);
        else if (m_drop < DROP_MAX) m_drop++;
      end
      m_sweep++;
      if (m_sweep == ENTRIES) m_sweep = -1;
    end
  endfunction

  task automatic cycle(input logic f, input logic v, input logic [31:0] pc,
                       input logic tk, input logic [31:0] tg);
    bp_upd_t nu;
    nu = '{pc: pc, taken: tk, target: tg};
    bus.flush_req  = f;
    bus.upd_valid  = v;
    bus.upd_pc     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tg;
    @(posedge clk);
    model_edge(f, v, nu);
    #1;
    bus.flush_req = 1'b0;
    bus.upd_valid = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.flush_req = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_pc = '0;
    bus.upd_taken = 1'b0;
    bus.upd_target = '0;
    rst_n = 1'b0;
    #2;
    total++;
    if (bus.clr_valid !== 1'b1 || bus.clr_index !== '0 || bus.pred_enable !== 1'b0 ||
        bus.busy !== 1'b1 || bus.cflow_valid !== 1'b0 || bus.pc_d !== 32'h0 ||
        bus.cflow_target !== 32'h0 || bus.drop_cnt !== '0) begin
      bad++;
      $display("FAIL reset_vals: got clr=%b idx=%0d pe=%b busy=%b cv=%b pc=%h tg=%h drop=%0d want 1 0 0 1 0 0 0 0",
               bus.clr_valid, bus.clr_index, bus.pred_enable, bus.busy, bus.cflow_valid,
               bus.pc_d, bus.cflow_target, bus.drop_cnt);
    end
  endtask

  task automatic test_sweep();
    reset_dut();
    total++;
    if (bus.clr_index !== 6'd0 || bus.clr_valid !== 1'b1 || bus.pred_enable !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL sweep_start: got idx=%0d clr=%b pe=%b busy=%b want 0 1 0 1",
               bus.clr_index, bus.clr_valid, bus.pred_enable, bus.busy);
    end
    for (int i = 1; i < ENTRIES; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      total++;
      if (bus.clr_index !== IDX_W'(i) || bus.clr_valid !== 1'b1 || bus.pred_enable !== 1'b0) begin
        bad++;
        $display("FAIL sweep_idx: got idx=%0d clr=%b pe=%b want idx=%0d clr=1 pe=0",
                 bus.clr_index, bus.clr_valid, bus.pred_enable, i);
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (bus.clr_valid !== 1'b0 || bus.pred_enable !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL sweep_end: got clr=%b pe=%b busy=%b want 0 1 0",
               bus.clr_valid, bus.pred_enable, bus.busy);
    end
  endtask

  task automatic test_single();
    cycle(1'b0, 1'b1, 32'h100, 1'b1, 32'h200);
    total++;
    if (bus.cflow_valid !== 1'b1 || bus.pc_d !== 32'h100 || bus.cflow_taken !== 1'b1 ||
        bus.cflow_target !== 32'h200) begin
      bad++;
      $display("FAIL single_issue: got cv=%b pc=%h tk=%b tg=%h want 1 100 1 200",
               bus.cflow_valid, bus.pc_d, bus.cflow_taken, bus.cflow_target);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (bus.cflow_valid !== 1'b0 || bus.pc_d !== 32'h100 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL single_after: got cv=%b pc=%h busy=%b want 0 100 0",
               bus.cflow_valid, bus.pc_d, bus.busy);
    end
  endtask

  task automatic test_overflow();
    int budget;
    reset_dut();
    for (int k = 0; k < 6; k++)
      cycle(1'b0, 1'b1, 32'h1000 + 32'(k * 4), k[0], 32'h2000 + 32'(k * 4));
    total++;
    if (bus.drop_cnt !== 16'd2 || bus.cflow_valid !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drop: got drop=%0d cv=%b busy=%b want 2 0 1",
               bus.drop_cnt, bus.cflow_valid, bus.busy);
    end
    budget = 200;
    while (m_sweep >= 0 && budget > 0) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      budget--;
      total++;
      if (bus.cflow_valid !== 1'b0) begin
        bad++;
        $display("FAIL ovf_no_issue_in_sweep: got cv=%b want 0", bus.cflow_valid);
      end
    end
    if (budget == 0) begin
      bad++;
      $display("FAIL ovf_sweep_budget: got sweep still running want idle");
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      total++;
      if (bus.cflow_valid !== 1'b1 || bus.pc_d !== 32'h1000 + 32'(k * 4) ||
          bus.cflow_taken !== k[0] || bus.cflow_target !== 32'h2000 + 32'(k * 4)) begin
        bad++;
        $display("FAIL ovf_drain%0d: got cv=%b pc=%h tk=%b tg=%h want 1 %h %b %h", k,
                 bus.cflow_valid, bus.pc_d, bus.cflow_taken, bus.cflow_target,
                 32'h1000 + 32'(k * 4), k[0], 32'h2000 + 32'(k * 4));
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (bus.cflow_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ovf_drained: got cv=%b busy=%b want 0 0", bus.cflow_valid, bus.busy);
    end
  endtask

  task automatic test_flush_upd();
    int budget;
    cycle(1'b1, 1'b1, 32'hdead, 1'b1, 32'hbeef);
    total++;
    if (bus.drop_cnt !== 16'd2 || bus.clr_valid !== 1'b1 || bus.clr_index !== 6'd0 ||
        bus.pred_enable !== 1'b0 || bus.cflow_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_upd: got drop=%0d clr=%b idx=%0d pe=%b cv=%b want 2 1 0 0 0",
               bus.drop_cnt, bus.clr_valid, bus.clr_index, bus.pred_enable, bus.cflow_valid);
    end
    budget = 200;
    while (m_sweep >= 0 && budget > 0) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      budget--;
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (budget == 0 || bus.cflow_valid !== 1'b0 || bus.busy !== 1'b0 || bus.pc_d !== 32'h100c) begin
      bad++;
      $display("FAIL flush_upd_after: got budget=%0d cv=%b busy=%b pc=%h want cv=0 busy=0 pc=100c",
               budget, bus.cflow_valid, bus.busy, bus.pc_d);
    end
  endtask

  task automatic test_flush_sweep();
    int budget;
    reset_dut();
    cycle(1'b0, 1'b1, 32'h3000, 1'b1, 32'h4000);
    cycle(1'b0, 1'b1, 32'h3004, 1'b0, 32'h4004);
    budget = 64;
    while (m_sweep != 30 && budget > 0) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      budget--;
    end
    total++;
    if (bus.clr_index !== 6'd30) begin
      bad++;
      $display("FAIL flush_pre_idx: got idx=%0d want 30", bus.clr_index);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (bus.clr_index !== 6'd0 || bus.clr_valid !== 1'b1 || bus.cflow_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_restart: got idx=%0d clr=%b cv=%b want 0 1 0",
               bus.clr_index, bus.clr_valid, bus.cflow_valid);
    end
    for (int i = 1; i < ENTRIES; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      total++;
      if (bus.clr_index !== IDX_W'(i) || bus.clr_valid !== 1'b1 || bus.cflow_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_sweep_idx: got idx=%0d clr=%b cv=%b want %0d 1 0",
                 bus.clr_index, bus.clr_valid, bus.cflow_valid, i);
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (bus.clr_valid !== 1'b0 || bus.cflow_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_discard: got clr=%b cv=%b busy=%b want 0 0 0",
               bus.clr_valid, bus.cflow_valid, bus.busy);
    end
  endtask

  task automatic test_random();
    logic        f, v, tk;
    logic [31:0] pc, tg;
    logic        e_busy;
    logic [IDX_W-1:0] e_idx;
    for (int n = 0; n < 900; n++) begin
      f  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 9) < 6);
      pc = $urandom;
      tk = $urandom_range(0, 1) == 1;
      tg = $urandom;
      cycle(f, v, pc, tk, tg);
      e_busy = (m_sweep >= 0) || (m_q.size() > 0) || m_cv;
      e_idx  = (m_sweep >= 0) ? IDX_W'(m_sweep) : '0;
      total++;
      if (bus.clr_valid !== (m_sweep >= 0) || bus.pred_enable !== (m_sweep < 0) ||
          bus.clr_index !== e_idx) begin
        bad++;
        $display("FAIL rand_sweep@%0d: got clr=%b pe=%b idx=%0d want clr=%b idx=%0d",
                 n, bus.clr_valid, bus.pred_enable, bus.clr_index, m_sweep >= 0, e_idx);
      end
      total++;
      if (bus.cflow_valid !== m_cv || bus.pc_d !== m_out.pc || bus.cflow_taken !== m_out.taken ||
          bus.cflow_target !== m_out.target) begin
        bad++;
        $display("FAIL rand_cflow@%0d: got cv=%b pc=%h tk=%b tg=%h want %b %h %b %h", n,
                 bus.cflow_valid, bus.pc_d, bus.cflow_taken, bus.cflow_target,
                 m_cv, m_out.pc, m_out.taken, m_out.target);
      end
      total++;
      if (bus.busy !== e_busy || bus.drop_cnt !== DROP_W'(m_drop)) begin
        bad++;
        $display("FAIL rand_status@%0d: got busy=%b drop=%0d want %b %0d",
                 n, bus.busy, bus.drop_cnt, e_busy, m_drop);
      end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int k = 0; k < 6; k++)
      cycle(1'b0, 1'b1, 32'h5000 + 32'(k), 1'b1, 32'h6000);
    total++;
    if (bus.drop_cnt !== 16'd2 || bus.clr_index !== 6'd6) begin
      bad++;
      $display("FAIL arst_pre: got drop=%0d idx=%0d want 2 6", bus.drop_cnt, bus.clr_index);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.clr_valid !== 1'b1 || bus.clr_index !== '0 || bus.pred_enable !== 1'b0 ||
        bus.busy !== 1'b1 || bus.cflow_valid !== 1'b0 || bus.pc_d !== 32'h0 || bus.drop_cnt !== '0) begin
      bad++;
      $display("FAIL arst_vals: got clr=%b idx=%0d pe=%b busy=%b cv=%b pc=%h drop=%0d want 1 0 0 1 0 0 0",
               bus.clr_valid, bus.clr_index, bus.pred_enable, bus.busy, bus.cflow_valid,
               bus.pc_d, bus.drop_cnt);
    end
    #2;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < ENTRIES + 1; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (bus.busy !== 1'b0 || bus.cflow_valid !== 1'b0 || bus.pred_enable !== 1'b1) begin
      bad++;
      $display("FAIL arst_queue_gone: got busy=%b cv=%b pe=%b want 0 0 1",
               bus.busy, bus.cflow_valid, bus.pred_enable);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sweep();
    test_single();
    test_overflow();
    test_flush_upd();
    test_flush_sweep();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
